// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALUSystem sequencer: FSM states,
// opcodes, datapath select/function codes and the packed control word.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_L,
      ST_FETCH_H,
      ST_EXEC,
      ST_HALT
   } seq_state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_LDAR = 4'h8;
   localparam logic [3:0] OP_BRA  = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [1:0] FUN_CLEAR = 2'b00;
   localparam logic [1:0] FUN_LOAD  = 2'b01;
   localparam logic [1:0] FUN_INC   = 2'b10;
   localparam logic [1:0] FUN_DEC   = 2'b11;

   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_MEM = 2'b01;
   localparam logic [1:0] MUX_IMM = 2'b10;
   localparam logic [1:0] MUX_ARF = 2'b11;
   localparam logic       MUXC_RF  = 1'b0;
   localparam logic       MUXC_ARF = 1'b1;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0101;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_OR     = 4'b1000;

   localparam logic [1:0] ARF_SEL_AR = 2'b00;
   localparam logic [1:0] ARF_SEL_SP = 2'b01;
   localparam logic [1:0] ARF_SEL_PC = 2'b10;
   localparam logic [3:0] ARF_EN_AR  = 4'b1000;
   localparam logic [3:0] ARF_EN_SP  = 4'b0100;
   localparam logic [3:0] ARF_EN_PC  = 4'b0010;

   // Field order follows the ALUSystem port list.
   typedef struct packed {
      logic [2:0] rf_o1_sel;
      logic [2:0] rf_o2_sel;
      logic [1:0] rf_funsel;
      logic [3:0] rf_rsel;
      logic [3:0] rf_tsel;
      logic [3:0] alu_funsel;
      logic [1:0] arf_outa_sel;
      logic [1:0] arf_outb_sel;
      logic [1:0] arf_funsel;
      logic [3:0] arf_rsel;
      logic       ir_lh;
      logic       ir_enable;
      logic [1:0] ir_funsel;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic       mux_c_sel;
   } ctrl_word_t;

   // Quiescent word: nothing enabled, memory deselected (CS is active-low).
   function automatic ctrl_word_t ctrl_idle();
      ctrl_word_t c;
      c        = '0;
      c.mem_cs = 1'b1;
      return c;
   endfunction

   // Register-file write enable is one-hot with R1 in the MSB.
   function automatic logic [3:0] rf_onehot(input logic [1:0] r);
      return 4'b1000 >> r;
   endfunction

   // Register-file output select for R(r+1).
   function automatic logic [2:0] rf_out(input logic [1:0] r);
      return {1'b1, r};
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational control-word generator: maps FSM state, instruction register
// and ALU flags onto every ALUSystem control input.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  seq_state_t  state,
   input  logic [15:0] ir_in,
   input  logic [3:0]  flags_in,
   output ctrl_word_t  ctrl
);

   logic [3:0] op;
   logic [1:0] rd;
   logic [1:0] rs1;
   logic [1:0] rs2;
   logic       zero_flag;
   logic       unused_flags;

   assign op           = ir_in[15:12];
   assign rd           = ir_in[11:10];
   assign rs1          = ir_in[9:8];
   assign rs2          = ir_in[7:6];
   assign zero_flag    = flags_in[3];
   assign unused_flags = ^flags_in[2:0];

   // Both fetch cycles read memory at PC into one IR half and bump PC;
   // execute drives the datapath for the decoded opcode.
   always_comb begin
      ctrl = ctrl_idle();
      case (state)
         ST_FETCH_L, ST_FETCH_H: begin
            ctrl.mem_cs       = 1'b0;
            ctrl.mem_wr       = 1'b0;
            ctrl.arf_outb_sel = ARF_SEL_PC;
            ctrl.ir_enable    = 1'b1;
            ctrl.ir_lh        = (state == ST_FETCH_H);
            ctrl.ir_funsel    = FUN_LOAD;
            ctrl.arf_rsel     = ARF_EN_PC;
            ctrl.arf_funsel   = FUN_INC;
         end
         ST_EXEC: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  ctrl.rf_o1_sel = rf_out(rs1);
                  ctrl.rf_o2_sel = rf_out(rs2);
                  ctrl.mux_c_sel = MUXC_RF;
                  case (op)
                     OP_ADD:  ctrl.alu_funsel = ALU_ADD;
                     OP_SUB:  ctrl.alu_funsel = ALU_SUB;
                     OP_AND:  ctrl.alu_funsel = ALU_AND;
                     default: ctrl.alu_funsel = ALU_OR;
                  endcase
                  ctrl.mux_a_sel = MUX_ALU;
                  ctrl.rf_funsel = FUN_LOAD;
                  ctrl.rf_rsel   = rf_onehot(rd);
               end
               OP_MOV: begin
                  ctrl.rf_o1_sel  = rf_out(rs1);
                  ctrl.mux_c_sel  = MUXC_RF;
                  ctrl.alu_funsel = ALU_PASS_A;
                  ctrl.mux_a_sel  = MUX_ALU;
                  ctrl.rf_funsel  = FUN_LOAD;
                  ctrl.rf_rsel    = rf_onehot(rd);
               end
               OP_LDI: begin
                  ctrl.mux_a_sel = MUX_IMM;
                  ctrl.rf_funsel = FUN_LOAD;
                  ctrl.rf_rsel   = rf_onehot(rd);
               end
               OP_LD: begin
                  ctrl.arf_outb_sel = ARF_SEL_AR;
                  ctrl.mem_cs       = 1'b0;
                  ctrl.mux_a_sel    = MUX_MEM;
                  ctrl.rf_funsel    = FUN_LOAD;
                  ctrl.rf_rsel      = rf_onehot(rd);
               end
               OP_ST: begin
                  ctrl.arf_outb_sel = ARF_SEL_AR;
                  ctrl.rf_o1_sel    = rf_out(rd);
                  ctrl.mux_c_sel    = MUXC_RF;
                  ctrl.alu_funsel   = ALU_PASS_A;
                  ctrl.mem_cs       = 1'b0;
                  ctrl.mem_wr       = 1'b1;
               end
               OP_LDAR: begin
                  ctrl.mux_b_sel  = MUX_IMM;
                  ctrl.arf_funsel = FUN_LOAD;
                  ctrl.arf_rsel   = ARF_EN_AR;
               end
               OP_BRA: begin
                  ctrl.mux_b_sel  = MUX_IMM;
                  ctrl.arf_funsel = FUN_LOAD;
                  ctrl.arf_rsel   = ARF_EN_PC;
               end
               OP_BEQ: begin
                  if (zero_flag) begin
                     ctrl.mux_b_sel  = MUX_IMM;
                     ctrl.arf_funsel = FUN_LOAD;
                     ctrl.arf_rsel   = ARF_EN_PC;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_system_sequencer.sv
// Multi-cycle control unit for ALUSystem: fetch-low, fetch-high, execute,
// with a start/halt handshake and a retired-instruction counter.
module alu_system_sequencer
   import alu_seq_pkg::*;
#(
   parameter int ICNT_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              start,
   input  logic [15:0]       ir_in,
   input  logic [3:0]        flags_in,
   output logic              busy,
   output logic              halted,
   output logic [ICNT_W-1:0] icount,
   output logic [2:0]        RF_O1Sel,
   output logic [2:0]        RF_O2Sel,
   output logic [1:0]        RF_FunSel,
   output logic [3:0]        RF_RSel,
   output logic [3:0]        RF_TSel,
   output logic [3:0]        ALU_FunSel,
   output logic [1:0]        ARF_OutASel,
   output logic [1:0]        ARF_OutBSel,
   output logic [1:0]        ARF_FunSel,
   output logic [3:0]        ARF_RSel,
   output logic              IR_LH,
   output logic              IR_Enable,
   output logic [1:0]        IR_Funsel,
   output logic              Mem_WR,
   output logic              Mem_CS,
   output logic [1:0]        MuxASel,
   output logic [1:0]        MuxBSel,
   output logic              MuxCSel
);

   seq_state_t state;
   seq_state_t state_next;
   ctrl_word_t dec_ctrl;
   ctrl_word_t ctrl;

   alu_seq_decode u_decode (
      .state    (state),
      .ir_in    (ir_in),
      .flags_in (flags_in),
      .ctrl     (dec_ctrl)
   );

   // State register; reset overrides everything, including a pending start.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Every pass through EXEC retires one instruction, HLT included.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         icount <= '0;
      end else if (state == ST_EXEC) begin
         icount <= icount + {{(ICNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Next-state logic; start only matters while parked in IDLE or HALT.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_HALT: if (start) state_next = ST_FETCH_L;
         ST_FETCH_L:       state_next = ST_FETCH_H;
         ST_FETCH_H:       state_next = ST_EXEC;
         ST_EXEC:          state_next = (ir_in[15:12] == OP_HLT) ? ST_HALT : ST_FETCH_L;
         default:          state_next = ST_IDLE;
      endcase
   end

   // During a reset cycle the datapath sees the quiescent word so an
   // in-flight fetch or execute cannot load a register or write memory.
   always_comb begin
      ctrl = dec_ctrl;
      if (Reset) ctrl = ctrl_idle();
   end

   assign busy   = (state == ST_FETCH_L) || (state == ST_FETCH_H) || (state == ST_EXEC);
   assign halted = (state == ST_HALT);

   assign RF_O1Sel    = ctrl.rf_o1_sel;
   assign RF_O2Sel    = ctrl.rf_o2_sel;
   assign RF_FunSel   = ctrl.rf_funsel;
   assign RF_RSel     = ctrl.rf_rsel;
   assign RF_TSel     = ctrl.rf_tsel;
   assign ALU_FunSel  = ctrl.alu_funsel;
   assign ARF_OutASel = ctrl.arf_outa_sel;
   assign ARF_OutBSel = ctrl.arf_outb_sel;
   assign ARF_FunSel  = ctrl.arf_funsel;
   assign ARF_RSel    = ctrl.arf_rsel;
   assign IR_LH       = ctrl.ir_lh;
   assign IR_Enable   = ctrl.ir_enable;
   assign IR_Funsel   = ctrl.ir_funsel;
   assign Mem_WR      = ctrl.mem_wr;
   assign Mem_CS      = ctrl.mem_cs;
   assign MuxASel     = ctrl.mux_a_sel;
   assign MuxBSel     = ctrl.mux_b_sel;
   assign MuxCSel     = ctrl.mux_c_sel;

endmodule

// File: tb/tb_alu_system_sequencer.sv
// Bench for alu_system_sequencer: the DUT drives a behavioural ALUSystem
// model, and architectural state is compared against an instruction-level
// reference interpreter.
module tb_alu_system_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] ir_in;
   logic [3:0]  flags_in;
   logic        busy, halted;
   logic [15:0] icount;
   logic [2:0]  RF_O1Sel, RF_O2Sel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
   logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
   logic [3:0]  ARF_RSel;
   logic        IR_LH, IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel;

   int errors = 0;
   int checks = 0;

   alu_system_sequencer #(.ICNT_W(16)) dut (
      .Clock(Clock), .Reset(Reset), .start(start), .ir_in(ir_in), .flags_in(flags_in),
      .busy(busy), .halted(halted), .icount(icount),
      .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel),
      .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel), .ARF_OutASel(ARF_OutASel),
      .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel),
      .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
      .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
   );

   always #5 Clock = ~Clock;

   // Reference interpreter state
   logic [7:0]  refMem [256];
   logic [7:0]  refR [4];
   logic [7:0]  refAR, refPC;
   logic        refZ, refHalted;
   logic [15:0] refIcount;

   // Behavioural ALUSystem datapath state
   logic [7:0]  dpMem [256];
   logic [7:0]  dpR [4];
   logic [7:0]  dpAR, dpSP, dpPC;
   logic [15:0] dpIR;
   logic        dpZ;
   logic        dpLoad = 1'b0;
   int          wrCount = 0;

   logic [7:0] addrB, addrA, memOut, o1, o2, aluA, aluOut, muxAOut, muxBOut;

   assign ir_in    = dpIR;
   assign flags_in = {dpZ, 3'b000};

   // Combinational datapath: register outputs, muxes and ALU
   always_comb begin
      addrB = (ARF_OutBSel == 2'b00) ? dpAR : (ARF_OutBSel == 2'b01) ? dpSP : dpPC;
      addrA = (ARF_OutASel == 2'b00) ? dpAR : (ARF_OutASel == 2'b01) ? dpSP : dpPC;
      memOut = dpMem[addrB];
      o1 = RF_O1Sel[2] ? dpR[RF_O1Sel[1:0]] : 8'h00;
      o2 = RF_O2Sel[2] ? dpR[RF_O2Sel[1:0]] : 8'h00;
      aluA = MuxCSel ? addrA : o1;
      case (ALU_FunSel)
         4'b0100: aluOut = aluA + o2;
         4'b0101: aluOut = aluA - o2;
         4'b0111: aluOut = aluA & o2;
         4'b1000: aluOut = aluA | o2;
         default: aluOut = aluA;
      endcase
      case (MuxASel)
         2'b00:   muxAOut = aluOut;
         2'b01:   muxAOut = memOut;
         2'b10:   muxAOut = dpIR[7:0];
         default: muxAOut = addrA;
      endcase
      case (MuxBSel)
         2'b00:   muxBOut = aluOut;
         2'b01:   muxBOut = memOut;
         2'b10:   muxBOut = dpIR[7:0];
         default: muxBOut = addrA;
      endcase
   end

   function automatic logic [7:0] applyFun(input logic [1:0] f, input logic [7:0] cur, input logic [7:0] d);
      case (f)
         2'b00:   return 8'h00;
         2'b01:   return d;
         2'b10:   return cur + 8'd1;
         default: return cur - 8'd1;
      endcase
   endfunction

   // Clocked datapath; dpLoad copies the reference state in
   always @(posedge Clock) begin
      if (dpLoad) begin
         for (int i = 0; i < 256; i++) dpMem[i] <= refMem[i];
         for (int i = 0; i < 4; i++) dpR[i] <= refR[i];
         dpAR <= refAR; dpSP <= 8'h00; dpPC <= refPC; dpZ <= refZ; dpIR <= 16'h0000;
      end else begin
         if (!Mem_CS && Mem_WR) dpMem[addrB] <= aluOut;
         if (IR_Enable && IR_Funsel == 2'b01) begin
            if (IR_LH) dpIR[15:8] <= memOut;
            else       dpIR[7:0]  <= memOut;
         end
         for (int i = 0; i < 4; i++)
            if (RF_RSel[3-i]) dpR[i] <= applyFun(RF_FunSel, dpR[i], muxAOut);
         if (ARF_RSel[3]) dpAR <= applyFun(ARF_FunSel, dpAR, muxBOut);
         if (ARF_RSel[2]) dpSP <= applyFun(ARF_FunSel, dpSP, muxBOut);
         if (ARF_RSel[1]) dpPC <= applyFun(ARF_FunSel, dpPC, muxBOut);
         if (RF_RSel != 4'b0000 && MuxASel == 2'b00) dpZ <= (aluOut == 8'h00);
      end
      if (Mem_WR && !Mem_CS) wrCount <= wrCount + 1;
   end

   // Instruction-level reference: one whole instruction per call
   task automatic ref_step();
      logic [15:0] ir;
      logic [7:0]  res, a, b, imm;
      logic [1:0]  rd;
      ir = {refMem[refPC + 8'd1], refMem[refPC]};
      refPC = refPC + 8'd2;
      rd = ir[11:10]; a = refR[ir[9:8]]; b = refR[ir[7:6]]; imm = ir[7:0];
      refHalted = 1'b0;
      case (ir[15:12])
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
            case (ir[15:12])
               4'h0:    res = a + b;
               4'h1:    res = a - b;
               4'h2:    res = a & b;
               4'h3:    res = a | b;
               default: res = a;
            endcase
            refR[rd] = res; refZ = (res == 8'h00);
         end
         4'h5: refR[rd] = imm;
         4'h6: refR[rd] = refMem[refAR];
         4'h7: refMem[refAR] = refR[rd];
         4'h8: refAR = imm;
         4'h9: refPC = imm;
         4'hA: if (refZ) refPC = imm;
         4'hF: refHalted = 1'b1;
         default: ;
      endcase
      refIcount = refIcount + 16'd1;
   endtask

   task automatic put_word(input logic [7:0] addr, input logic [15:0] w);
      refMem[addr] = w[7:0];
      refMem[addr + 8'd1] = w[15:8];
   endtask

   // Pulse start from IDLE/HALT; returns at the negedge inside FETCH_L
   task automatic start_run();
      start = 1'b1;
      @(negedge Clock);
      start = 1'b0;
   endtask

   // Run one fetch/fetch/execute; start may be toggled while busy
   task automatic exec_one(input bit noisyStart);
      for (int c = 0; c < 3; c++) begin
         start = noisyStart ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge Clock);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
      for (int i = 0; i < 4; i++) refR[i] = 8'h00;
      refAR = 8'h00; refPC = 8'h00; refZ = 1'b0; refHalted = 1'b0; refIcount = 16'd0;
      put_word(8'h00, 16'h5110);
      put_word(8'h02, 16'h5005);
      put_word(8'h04, 16'h5403);
      put_word(8'h06, 16'h0840);
      put_word(8'h08, 16'h1C00);
      put_word(8'h0A, 16'hA040);
      put_word(8'h40, 16'h8080);
      put_word(8'h42, 16'h7800);
      put_word(8'h44, 16'h6C00);
      put_word(8'h46, 16'hF000);
      put_word(8'h48, 16'h5477);
      Reset = 1'b1; dpLoad = 1'b1; start = 1'b1;
      repeat (2) @(negedge Clock);
      checks++;
      if ({busy, halted, Mem_CS, Mem_WR, IR_Enable, RF_RSel, ARF_RSel} !== {3'b001, 2'b00, 8'h00}) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: busy=%b halted=%b cs=%b wr=%b ire=%b rsel=%h arsel=%h, expected 0 0 1 0 0 0 0",
                  busy, halted, Mem_CS, Mem_WR, IR_Enable, RF_RSel, ARF_RSel);
      end
      start = 1'b0; Reset = 1'b0; dpLoad = 1'b0;
      @(negedge Clock);
      checks++;
      if (busy !== 1'b0 || icount !== 16'd0 || Mem_CS !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_idle: busy=%b icount=%0d cs=%b, expected 0 0 1", busy, icount, Mem_CS);
      end
   endtask

   task automatic test_first_ldi();
      start_run();
      checks++;
      if (busy !== 1'b1 || IR_Enable !== 1'b1 || Mem_CS !== 1'b0 || IR_LH !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_low: busy=%b ire=%b cs=%b lh=%b, expected 1 1 0 0", busy, IR_Enable, Mem_CS, IR_LH);
      end
      exec_one(1'b0); ref_step();
      checks++;
      if (dpR[0] !== 8'h10 || dpPC !== 8'h02 || icount !== 16'd1) begin
         errors++;
         $display("[TB] FAIL first_ldi: R1=%h PC=%h icount=%0d, expected 10 02 1", dpR[0], dpPC, icount);
      end
   endtask

   task automatic test_alu_branch();
      repeat (3) begin exec_one(1'b0); ref_step(); end
      checks++;
      if (dpR[2] !== 8'h08) begin
         errors++;
         $display("[TB] FAIL add: R3=%h, expected 08", dpR[2]);
      end
      exec_one(1'b0); ref_step();
      checks++;
      if (dpR[3] !== 8'h00 || dpZ !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sub_zero: R4=%h Z=%b, expected 00 1", dpR[3], dpZ);
      end
      exec_one(1'b0); ref_step();
      checks++;
      if (dpPC !== 8'h40) begin
         errors++;
         $display("[TB] FAIL beq_taken: PC=%h, expected 40", dpPC);
      end
   endtask

   task automatic test_mem_access();
      int wrBefore;
      exec_one(1'b0); ref_step();
      wrBefore = wrCount;
      exec_one(1'b0); ref_step();
      checks++;
      if (dpMem[8'h80] !== 8'h08 || (wrCount - wrBefore) != 1) begin
         errors++;
         $display("[TB] FAIL store: M[80]=%h write_cycles=%0d, expected 08 1", dpMem[8'h80], wrCount - wrBefore);
      end
      exec_one(1'b0); ref_step();
      checks++;
      if (dpR[3] !== 8'h08) begin
         errors++;
         $display("[TB] FAIL load: R4=%h, expected 08", dpR[3]);
      end
   endtask

   task automatic test_halt_resume();
      exec_one(1'b0); ref_step();
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || icount !== 16'd10) begin
         errors++;
         $display("[TB] FAIL halt: halted=%b busy=%b icount=%0d, expected 1 0 10", halted, busy, icount);
      end
      repeat (3) @(negedge Clock);
      checks++;
      if (halted !== 1'b1 || icount !== 16'd10 || Mem_CS !== 1'b1 || dpPC !== 8'h48) begin
         errors++;
         $display("[TB] FAIL halt_hold: halted=%b icount=%0d cs=%b PC=%h, expected 1 10 1 48", halted, icount, Mem_CS, dpPC);
      end
      start_run(); exec_one(1'b0); ref_step();
      checks++;
      if (dpR[1] !== 8'h77 || dpPC !== 8'h4A || icount !== 16'd11 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL resume: R2=%h PC=%h icount=%0d busy=%b, expected 77 4A 11 1", dpR[1], dpPC, icount, busy);
      end
   endtask

   task automatic test_reset_during_fetch();
      int wrBefore;
      @(negedge Clock);
      wrBefore = wrCount;
      Reset = 1'b1; start = 1'b1;
      #1;
      checks++;
      if (IR_Enable !== 1'b0 || Mem_WR !== 1'b0 || ARF_RSel !== 4'h0 || RF_RSel !== 4'h0) begin
         errors++;
         $display("[TB] FAIL reset_fetch_ctrl: ire=%b wr=%b arsel=%h rsel=%h, expected 0 0 0 0", IR_Enable, Mem_WR, ARF_RSel, RF_RSel);
      end
      @(negedge Clock);
      Reset = 1'b0; start = 1'b0;
      @(negedge Clock);
      checks++;
      if (busy !== 1'b0 || halted !== 1'b0 || icount !== 16'd0 || dpPC !== 8'h4B || wrCount != wrBefore) begin
         errors++;
         $display("[TB] FAIL reset_fetch: busy=%b halted=%b icount=%0d PC=%h writes=%0d, expected 0 0 0 4B 0",
                  busy, halted, icount, dpPC, wrCount - wrBefore);
      end
   endtask

   task automatic test_random_program();
      int memBad;
      for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) refR[i] = 8'($urandom);
      refAR = 8'($urandom); refPC = 8'($urandom); refZ = 1'($urandom);
      refHalted = 1'b0; refIcount = 16'd0;
      Reset = 1'b1; dpLoad = 1'b1;
      @(negedge Clock);
      Reset = 1'b0; dpLoad = 1'b0;
      start_run();
      for (int n = 0; n < 150; n++) begin
         exec_one(1'b1); ref_step();
         checks++;
         if ({dpR[0], dpR[1], dpR[2], dpR[3], dpAR, dpPC, dpZ} !== {refR[0], refR[1], refR[2], refR[3], refAR, refPC, refZ}) begin
            errors++;
            $display("[TB] FAIL rand_arch[%0d]: R=%h %h %h %h AR=%h PC=%h Z=%b, expected R=%h %h %h %h AR=%h PC=%h Z=%b", n,
                     dpR[0], dpR[1], dpR[2], dpR[3], dpAR, dpPC, dpZ, refR[0], refR[1], refR[2], refR[3], refAR, refPC, refZ);
         end
         checks++;
         if (icount !== refIcount || halted !== refHalted || busy !== !refHalted) begin
            errors++;
            $display("[TB] FAIL rand_status[%0d]: icount=%0d halted=%b busy=%b, expected %0d %b %b", n,
                     icount, halted, busy, refIcount, refHalted, !refHalted);
         end
         if (refHalted) start_run();
      end
      memBad = 0;
      for (int i = 0; i < 256; i++) if (dpMem[i] !== refMem[i]) memBad++;
      checks++;
      if (memBad != 0) begin
         errors++;
         $display("[TB] FAIL rand_memory: %0d differing bytes, expected 0", memBad);
      end
   endtask

   initial begin
      test_reset();
      test_first_ldi();
      test_alu_branch();
      test_mem_access();
      test_halt_resume();
      test_reset_during_fetch();
      test_random_program();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
